// File: rtl/pwm_pkg.sv
// Shared constants for the enhanced PWM block: prescaler width and default resolution.
package pwm_pkg;
  localparam int unsigned DVSR_W        = 32;
  localparam int unsigned PWM_R_DEFAULT = 8;
endpackage

// File: rtl/pwm_prescaler.sv
// Step-tick prescaler: counts 0..dvsr and wraps; tick marks the last clock of each step.
module pwm_prescaler
  import pwm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DVSR_W-1:0] dvsr,
  output logic              tick
);

  logic [DVSR_W-1:0] count;

  // >= rather than == so a divisor lowered below the running count wraps at once
  assign tick = (count >= dvsr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     count <= '0;
    else if (tick) count <= '0;
    else           count <= count + 1'b1;
  end

endmodule

// File: rtl/pwm_enhanced.sv
// Enhanced PWM: prescaled R-bit duty counter, registered compare output.
// Optional PWM_ENHANCED_SYNC_UPDATE_EN shadows duty/dvsr so updates land at period start.
module pwm_enhanced
  import pwm_pkg::*;
#(
  parameter int unsigned R = PWM_R_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [R:0]        duty,
  input  logic [DVSR_W-1:0] dvsr,
  output logic              pwm_out
);

  logic              tick;
  logic [R-1:0]      d_cnt;
  logic [R:0]        duty_eff;
  logic [DVSR_W-1:0] dvsr_eff;
  logic              pwm_next;

`ifdef PWM_ENHANCED_SYNC_UPDATE_EN
  logic              first_cycle;
  logic              load;
  logic [R:0]        duty_sh;
  logic [DVSR_W-1:0] dvsr_sh;

  assign load = first_cycle | (tick & (d_cnt == '1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_cycle <= 1'b1;
      duty_sh     <= '0;
      dvsr_sh     <= '0;
    end else begin
      first_cycle <= 1'b0;
      if (load) begin
        duty_sh <= duty;
        dvsr_sh <= dvsr;
      end
    end
  end

  // Shadows are still empty in the first cycle after reset, so bypass to the live inputs
  assign duty_eff = first_cycle ? duty : duty_sh;
  assign dvsr_eff = first_cycle ? dvsr : dvsr_sh;
`else
  assign duty_eff = duty;
  assign dvsr_eff = dvsr;
`endif

  pwm_prescaler u_prescaler (
    .clk   (clk),
    .reset (reset),
    .dvsr  (dvsr_eff),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     d_cnt <= '0;
    else if (tick) d_cnt <= d_cnt + 1'b1;
  end

  always_comb begin
    pwm_next = ({1'b0, d_cnt} < duty_eff);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pwm_out <= 1'b0;
    else        pwm_out <= pwm_next;
  end

endmodule

// File: tb/tb_pwm_enhanced.sv
// Self-checking bench for pwm_enhanced: R=4 and R=10 instances, table vectors,
// hand-written corner sequences and randomized duty changes against a closed-form model.
module tb_pwm_enhanced;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4  = 1'b1;
  logic [4:0]  duty4 = '0;
  logic [31:0] dvsr4 = '0;
  logic        pwm4;

  logic        rst10  = 1'b1;
  logic [10:0] duty10 = '0;
  logic [31:0] dvsr10 = '0;
  logic        pwm10;

  pwm_enhanced #(.R(4)) u4 (
    .clk     (clk),
    .reset   (rst4),
    .duty    (duty4),
    .dvsr    (dvsr4),
    .pwm_out (pwm4)
  );

  pwm_enhanced #(.R(10)) u10 (
    .clk     (clk),
    .reset   (rst10),
    .duty    (duty10),
    .dvsr    (dvsr10),
    .pwm_out (pwm10)
  );

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  typedef struct {
    int unsigned dvsr;
    int unsigned duty;
    int unsigned exp_high;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start4(input int unsigned dv, input int unsigned du);
    rst4  = 1'b1;
    dvsr4 = dv;
    duty4 = 5'(du);
    repeat (3) @(posedge clk);
    #1;
    check("reset_state_r4", 32'(pwm4), 0);
    rst4 = 1'b0;
  endtask

  task automatic start10(input int unsigned du);
    rst10  = 1'b1;
    dvsr10 = '0;
    duty10 = 11'(du);
    repeat (10) @(posedge clk);
    #1;
    check("reset_state_r10", 32'(pwm10), 0);
    rst10 = 1'b0;
  endtask

  initial begin
    int unsigned hi, hi2, period, n, p, src, d, dc, dv, du;
    logic        prev, contig;
    int unsigned duty_at[];

    tbl[0] = '{3, 8, 32};
    tbl[1] = '{0, 5, 5};
    tbl[2] = '{1, 16, 32};
    tbl[3] = '{2, 0, 0};
    tbl[4] = '{0, 15, 15};
    tbl[5] = '{4, 1, 5};
    tbl[6] = '{0, 31, 16};
    tbl[7] = '{2, 9, 27};

    // Table: high-time within the first period, and high must be a single run from start
    for (int i = 0; i < 8; i++) begin
      start4(tbl[i].dvsr, tbl[i].duty);
      period = 16 * (tbl[i].dvsr + 1);
      hi = 0; prev = 1'b1; contig = 1'b1;
      for (int unsigned k = 1; k <= period; k++) begin
        @(posedge clk); #1;
        if (k == 1) check("tbl_first_edge", 32'(pwm4), (tbl[i].duty > 0) ? 1 : 0);
        if (pwm4) hi++;
        if (pwm4 && !prev) contig = 1'b0;
        prev = pwm4;
      end
      check("tbl_high_count", hi, tbl[i].exp_high);
      check("tbl_contiguous", 32'(contig), 1);
    end

    // Asynchronous reset in the middle of a high phase
    start4(3, 8);
    repeat (10) @(posedge clk);
    #1;
    check("mid_high_before_reset", 32'(pwm4), 1);
    #3 rst4 = 1'b1;
    #1 check("async_reset_between_edges", 32'(pwm4), 0);
    @(posedge clk); #1;
    check("reset_held", 32'(pwm4), 0);
    @(posedge clk); #1;
    rst4 = 1'b0;
    hi = 0; hi2 = 0;
    for (int unsigned k = 1; k <= 64; k++) begin
      @(posedge clk); #1;
      if (k <= 32) hi += 32'(pwm4);
      else         hi2 += 32'(pwm4);
    end
    check("restart_high_half", hi, 32);
    check("restart_low_half", hi2, 0);

    // Duty change 4 -> 12 once the duty counter reaches 2
    start4(0, 4);
    hi = 0; hi2 = 0;
    for (int unsigned k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      if (k == 2) duty4 = 5'd12;
      if (k <= 16) hi += 32'(pwm4);
      else         hi2 += 32'(pwm4);
    end
`ifdef PWM_ENHANCED_SYNC_UPDATE_EN
    check("duty_change_cur_period", hi, 4);
`else
    check("duty_change_cur_period", hi, 12);
`endif
    check("duty_change_next_period", hi2, 12);

    // Divisor lowered below the running prescaler count must wrap, not stall
    start4(10, 1);
    hi = 0;
    for (int unsigned k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 7) dvsr4 = 32'd2;
      hi += 32'(pwm4);
    end
`ifdef PWM_ENHANCED_SYNC_UPDATE_EN
    check("dvsr_lowered_high", hi, 11);
`else
    check("dvsr_lowered_high", hi, 8);
`endif

    // R=10 scenarios, per-edge against closed form
    start10(127);
    hi = 0;
    for (int unsigned k = 1; k <= 2048; k++) begin
      @(posedge clk); #1;
      check("r10_duty127", 32'(pwm10), (((k - 1) % 1024) < 127) ? 1 : 0);
      hi += 32'(pwm10);
    end
    check("r10_duty127_total", hi, 254);

    start10(0);
    for (int unsigned k = 1; k <= 3000; k++) begin
      @(posedge clk); #1;
      check("r10_duty0", 32'(pwm10), 0);
    end

    start10(1024);
    for (int unsigned k = 1; k <= 3000; k++) begin
      @(posedge clk); #1;
      if (k >= 2) check("r10_duty_full", 32'(pwm10), 1);
    end

    // Randomized: per edge, the duty counter value is ((k-1)/(dvsr+1)) mod 16
    for (int t = 0; t < 8; t++) begin
      dv = $urandom_range(0, 4);
      du = $urandom_range(0, 20);
      start4(dv, du);
      period = 16 * (dv + 1);
      n = 3 * period;
      duty_at = new[n + 1];
      for (int unsigned k = 1; k <= n; k++) begin
        if ($urandom_range(0, 7) == 0) duty4 = 5'($urandom_range(0, 20));
        duty_at[k] = 32'(duty4);
        @(posedge clk); #1;
        dc = ((k - 1) / (dv + 1)) % 16;
        p  = (k - 1) / period;
`ifdef PWM_ENHANCED_SYNC_UPDATE_EN
        src = (p == 0) ? 1 : p * period;
`else
        src = k;
`endif
        d = duty_at[src];
        check("random_model", 32'(pwm4), (dc < d) ? 1 : 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
